// File: rtl/exe_mem_stage_pkg.sv
// Shared memory-op encodings and helpers for the EXE->MEM stage and its store history.
package exe_mem_stage_pkg;

    localparam logic [2:0] MEM_NOP_OP = 3'd0;
    localparam logic [2:0] MEM_LB_OP  = 3'd1;
    localparam logic [2:0] MEM_LH_OP  = 3'd2;
    localparam logic [2:0] MEM_LW_OP  = 3'd3;
    localparam logic [2:0] MEM_SB_OP  = 3'd4;
    localparam logic [2:0] MEM_SH_OP  = 3'd5;
    localparam logic [2:0] MEM_SW_OP  = 3'd6;

    localparam logic [31:0] ZeroWord   = 32'h0;
    localparam logic [4:0]  NOPRegAddr = 5'h0;

    function automatic logic is_store(input logic [2:0] op);
        return (op == MEM_SB_OP) || (op == MEM_SH_OP) || (op == MEM_SW_OP);
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] lo);
        logic [3:0] m;
        case (op)
            MEM_SB_OP: m = 4'b0001 << lo;
            MEM_SH_OP: m = 4'b0011 << {lo[1], 1'b0};
            MEM_SW_OP: m = 4'hF;
            default:   m = 4'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/exe_mem_stage_store_history.sv
// Circular buffer of retired stores with a youngest-first, byte-mask-aware lookup.
module store_history #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [3:0]      wr_mask,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] lk_addr,
    output logic            lk_hit,
    output logic            lk_partial,
    output logic [XLEN-1:0] lk_data,
    output logic [XLEN-1:0] last_addr,
    output logic [XLEN-1:0] last_data
);
    import exe_mem_stage_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [XLEN-3:0]  word_q [DEPTH];
    logic [XLEN-3:0]  word_d [DEPTH];
    logic [3:0]       mask_q [DEPTH];
    logic [3:0]       mask_d [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];

    logic [PW-1:0]    lk_idx;
    logic             lk_found;
    logic [PW-1:0]    last_idx;

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        word_d   = word_q;
        mask_d   = mask_q;
        data_d   = data_q;
        if (wr_en) begin
            vld_d[wr_ptr_q]  = 1'b1;
            word_d[wr_ptr_q] = wr_addr[XLEN-1:2];
            mask_d[wr_ptr_q] = wr_mask;
            data_d[wr_ptr_q] = wr_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry payload is qualified by vld_q, so it carries no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
        mask_q <= mask_d;
        data_q <= data_d;
    end

    // Walk backwards from the newest slot; the first word-address match wins.
    always_comb begin
        lk_hit     = 1'b0;
        lk_partial = 1'b0;
        lk_data    = '0;
        lk_found   = 1'b0;
        lk_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = wr_ptr_q - PW'(i + 1);
            if (!lk_found && vld_q[lk_idx] && (word_q[lk_idx] == lk_addr[XLEN-1:2])) begin
                lk_found   = 1'b1;
                lk_hit     = (mask_q[lk_idx] == 4'hF);
                lk_partial = (mask_q[lk_idx] != 4'hF);
                lk_data    = data_q[lk_idx];
            end
        end
    end

    always_comb begin
        last_idx  = wr_ptr_q - PW'(1);
        last_addr = '0;
        last_data = '0;
        if (vld_q[last_idx]) begin
            last_addr = {word_q[last_idx], 2'b00};
            last_data = data_q[last_idx];
        end
    end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register with valid/ready handshake, flush, and store-history forwarding lookup.
module exe_mem_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic              flush,
    input  logic [XLEN-1:0]   exe_pc,
    input  logic [XLEN-1:0]   exe_mem_addr,
    input  logic [XLEN-1:0]   exe_mem_data,
    input  logic [XLEN-1:0]   exe_write_data,
    input  logic [OP_W-1:0]   exe_mem_op,
    input  logic              exe_we,
    input  logic [REG_AW-1:0] exe_write_reg,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_pc,
    output logic [XLEN-1:0]   mem_mem_addr,
    output logic [XLEN-1:0]   mem_mem_data,
    output logic [XLEN-1:0]   mem_write_data,
    output logic [OP_W-1:0]   mem_mem_op,
    output logic              mem_we,
    output logic [REG_AW-1:0] mem_write_reg,
    input  logic [XLEN-1:0]   fwd_addr,
    output logic              fwd_hit,
    output logic              fwd_partial,
    output logic [XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]   last_store_addr,
    output logic [XLEN-1:0]   last_store_data
);
    import exe_mem_stage_pkg::*;

    logic              mem_valid_q, mem_valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, addr_q, addr_d, data_q, data_d, wdata_q, wdata_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;

    logic capture;
    logic retire;

    assign exe_ready = !mem_valid_q || mem_ready;
    assign capture   = exe_valid && exe_ready && !flush;
    assign retire    = mem_valid_q && mem_ready && !flush && is_store(3'(op_q));

    always_comb begin
        mem_valid_d = mem_valid_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        we_d        = we_q;
        wreg_d      = wreg_q;
        if (flush) begin
            mem_valid_d = 1'b0;
            op_d        = OP_W'(MEM_NOP_OP);
            we_d        = 1'b0;
        end else if (capture) begin
            mem_valid_d = 1'b1;
            pc_d        = exe_pc;
            addr_d      = exe_mem_addr;
            data_d      = exe_mem_data;
            wdata_d     = exe_write_data;
            op_d        = exe_mem_op;
            we_d        = exe_we;
            wreg_d      = exe_write_reg;
        end else if (mem_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_q <= 1'b0;
            pc_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wdata_q     <= '0;
            op_q        <= OP_W'(MEM_NOP_OP);
            we_q        <= 1'b0;
            wreg_q      <= REG_AW'(NOPRegAddr);
        end else begin
            mem_valid_q <= mem_valid_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            we_q        <= we_d;
            wreg_q      <= wreg_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_pc         = pc_q;
    assign mem_mem_addr   = addr_q;
    assign mem_mem_data   = data_q;
    assign mem_write_data = wdata_q;
    assign mem_mem_op     = op_q;
    assign mem_we         = we_q;
    assign mem_write_reg  = wreg_q;

    store_history #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (retire),
        .wr_addr    (addr_q),
        .wr_mask    (store_mask(3'(op_q), addr_q[1:0])),
        .wr_data    (data_q),
        .lk_addr    (fwd_addr),
        .lk_hit     (fwd_hit),
        .lk_partial (fwd_partial),
        .lk_data    (fwd_data),
        .last_addr  (last_store_addr),
        .last_data  (last_store_data)
    );

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed table-driven bench for exe_mem_stage: handshake, flush, forwarding priority, wrap, async reset.
module tb_exe_mem_stage;
    import exe_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exe_valid = 1'b0;
    logic        exe_ready;
    logic        flush = 1'b0;
    logic [31:0] exe_pc = '0, exe_mem_addr = '0, exe_mem_data = '0, exe_write_data = '0;
    logic [2:0]  exe_mem_op = MEM_NOP_OP;
    logic        exe_we = 1'b0;
    logic [4:0]  exe_write_reg = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_pc, mem_mem_addr, mem_mem_data, mem_write_data;
    logic [2:0]  mem_mem_op;
    logic        mem_we;
    logic [4:0]  mem_write_reg;
    logic [31:0] fwd_addr = '0;
    logic        fwd_hit, fwd_partial;
    logic [31:0] fwd_data, last_store_addr, last_store_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exe_mem_stage #(.XLEN(32), .REG_AW(5), .OP_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .flush(flush),
        .exe_pc(exe_pc), .exe_mem_addr(exe_mem_addr), .exe_mem_data(exe_mem_data),
        .exe_write_data(exe_write_data), .exe_mem_op(exe_mem_op), .exe_we(exe_we),
        .exe_write_reg(exe_write_reg),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_mem_addr(mem_mem_addr), .mem_mem_data(mem_mem_data),
        .mem_write_data(mem_write_data), .mem_mem_op(mem_mem_op), .mem_we(mem_we),
        .mem_write_reg(mem_write_reg),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_partial(fwd_partial), .fwd_data(fwd_data),
        .last_store_addr(last_store_addr), .last_store_data(last_store_data)
    );

    typedef struct {
        logic        ev;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mr;
        logic        fl;
        logic [31:0] fa;
        logic        mv;
        logic        er;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [2:0]  mop;
        logic        hit;
        logic        part;
        logic [31:0] fd;
        logic [31:0] lsa;
        logic [31:0] lsd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic mr, input logic fl, input logic [31:0] fa);
        exe_valid      = ev;
        exe_mem_op     = op;
        exe_mem_addr   = addr;
        exe_mem_data   = data;
        exe_write_data = data;
        exe_pc         = addr + 32'h1000;
        exe_we         = (op == MEM_NOP_OP);
        exe_write_reg  = addr[6:2];
        mem_ready      = mr;
        flush          = fl;
        fwd_addr       = fa;
    endtask

    function automatic vec_t mk(input logic ev, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic mr, input logic fl,
                                input logic [31:0] fa, input logic mv, input logic er,
                                input logic mwe, input logic [31:0] maddr, input logic [31:0] mdata,
                                input logic [2:0] mop, input logic hit, input logic part,
                                input logic [31:0] fd, input logic [31:0] lsa, input logic [31:0] lsd);
        vec_t v;
        v.ev = ev; v.op = op; v.addr = addr; v.data = data; v.mr = mr; v.fl = fl; v.fa = fa;
        v.mv = mv; v.er = er; v.mwe = mwe; v.maddr = maddr; v.mdata = mdata; v.mop = mop;
        v.hit = hit; v.part = part; v.fd = fd; v.lsa = lsa; v.lsd = lsd;
        return v;
    endfunction

    initial begin
        // ALU stream with mem_ready=1, then a drain cycle
        vecs.push_back(mk(1, MEM_NOP_OP, 32'h10, 32'h1, 1, 0, 32'h0,  1, 1, 1, 32'h10, 32'h1, MEM_NOP_OP, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, MEM_NOP_OP, 32'h14, 32'h2, 1, 0, 32'h0,  1, 1, 1, 32'h14, 32'h2, MEM_NOP_OP, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, MEM_NOP_OP, 32'h18, 32'h3, 1, 0, 32'h0,  1, 1, 1, 32'h18, 32'h3, MEM_NOP_OP, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, MEM_NOP_OP, 32'h1C, 32'h4, 1, 0, 32'h0,  1, 1, 1, 32'h1C, 32'h4, MEM_NOP_OP, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, MEM_NOP_OP, 32'h0,  32'h0, 1, 0, 32'h0,  0, 1, 1, 32'h1C, 32'h4, MEM_NOP_OP, 0, 0, 0, 0, 0));
        // Stall: SW 0x40 held three cycles while the next SW waits
        vecs.push_back(mk(1, MEM_SW_OP, 32'h40, 32'h11111111, 0, 0, 32'h40, 1, 0, 0, 32'h40, 32'h11111111, MEM_SW_OP, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, MEM_SW_OP, 32'h40, 32'h22222222, 0, 0, 32'h40, 1, 0, 0, 32'h40, 32'h11111111, MEM_SW_OP, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, MEM_SW_OP, 32'h40, 32'h22222222, 0, 0, 32'h40, 1, 0, 0, 32'h40, 32'h11111111, MEM_SW_OP, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, MEM_SW_OP, 32'h40, 32'h22222222, 0, 0, 32'h40, 1, 0, 0, 32'h40, 32'h11111111, MEM_SW_OP, 0, 0, 0, 0, 0));
        // Release: retire + capture same cycle; youngest SW wins; SB gives partial
        vecs.push_back(mk(1, MEM_SW_OP, 32'h40, 32'h22222222, 1, 0, 32'h40, 1, 1, 0, 32'h40, 32'h22222222, MEM_SW_OP, 1, 0, 32'h11111111, 32'h40, 32'h11111111));
        vecs.push_back(mk(1, MEM_SB_OP, 32'h41, 32'h000000AB, 1, 0, 32'h40, 1, 1, 0, 32'h41, 32'h000000AB, MEM_SB_OP, 1, 0, 32'h22222222, 32'h40, 32'h22222222));
        vecs.push_back(mk(0, MEM_NOP_OP, 32'h0, 32'h0,        1, 0, 32'h40, 0, 1, 0, 32'h41, 32'h000000AB, MEM_SB_OP, 0, 1, 32'h000000AB, 32'h40, 32'h000000AB));
        // Flush of a held SW 0x100: nothing recorded
        vecs.push_back(mk(1, MEM_SW_OP, 32'h100, 32'hDEADBEEF, 0, 0, 32'h100, 1, 0, 0, 32'h100, 32'hDEADBEEF, MEM_SW_OP, 0, 0, 0, 32'h40, 32'hAB));
        vecs.push_back(mk(0, MEM_NOP_OP, 32'h0, 32'h0,         1, 1, 32'h100, 0, 1, 0, 32'h100, 32'hDEADBEEF, MEM_NOP_OP, 0, 0, 0, 32'h40, 32'hAB));
        // Wrap: five SWs overwrite the four-entry history
        vecs.push_back(mk(1, MEM_SW_OP, 32'h0,  32'hA0, 1, 0, 32'h0,  1, 1, 0, 32'h0,  32'hA0, MEM_SW_OP, 0, 0, 0,      32'h40, 32'hAB));
        vecs.push_back(mk(1, MEM_SW_OP, 32'h4,  32'hA4, 1, 0, 32'h0,  1, 1, 0, 32'h4,  32'hA4, MEM_SW_OP, 1, 0, 32'hA0, 32'h0,  32'hA0));
        vecs.push_back(mk(1, MEM_SW_OP, 32'h8,  32'hA8, 1, 0, 32'h0,  1, 1, 0, 32'h8,  32'hA8, MEM_SW_OP, 1, 0, 32'hA0, 32'h4,  32'hA4));
        vecs.push_back(mk(1, MEM_SW_OP, 32'hC,  32'hAC, 1, 0, 32'h40, 1, 1, 0, 32'hC,  32'hAC, MEM_SW_OP, 0, 1, 32'hAB, 32'h8,  32'hA8));
        vecs.push_back(mk(1, MEM_SW_OP, 32'h10, 32'hB0, 1, 0, 32'h40, 1, 1, 0, 32'h10, 32'hB0, MEM_SW_OP, 0, 0, 0,      32'hC,  32'hAC));
        vecs.push_back(mk(0, MEM_NOP_OP, 32'h0, 32'h0,  1, 0, 32'h0,  0, 1, 0, 32'h10, 32'hB0, MEM_SW_OP, 0, 0, 0,      32'h10, 32'hB0));
        vecs.push_back(mk(0, MEM_NOP_OP, 32'h0, 32'h0,  1, 0, 32'h10, 0, 1, 0, 32'h10, 32'hB0, MEM_SW_OP, 1, 0, 32'hB0, 32'h10, 32'hB0));

        // Reset state while rst is held low
        drive(0, MEM_NOP_OP, 32'h0, 32'h0, 1, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", -1, 32'(mem_valid), 32'h0);
        chk("rst_mem_op",    -1, 32'(mem_mem_op), 32'(MEM_NOP_OP));
        chk("rst_mem_addr",  -1, mem_mem_addr, 32'h0);
        chk("rst_fwd_hit",   -1, 32'(fwd_hit), 32'h0);
        chk("rst_last_addr", -1, last_store_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].ev, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mr, vecs[i].fl, vecs[i].fa);
            @(posedge clk);
            #1;
            chk("mem_valid",   i, 32'(mem_valid),   32'(vecs[i].mv));
            chk("exe_ready",   i, 32'(exe_ready),   32'(vecs[i].er));
            chk("mem_we",      i, 32'(mem_we),      32'(vecs[i].mwe));
            chk("mem_addr",    i, mem_mem_addr,     vecs[i].maddr);
            chk("mem_pc",      i, mem_pc,           vecs[i].maddr + 32'h1000);
            chk("mem_data",    i, mem_mem_data,     vecs[i].mdata);
            chk("mem_op",      i, 32'(mem_mem_op),  32'(vecs[i].mop));
            chk("fwd_hit",     i, 32'(fwd_hit),     32'(vecs[i].hit));
            chk("fwd_partial", i, 32'(fwd_partial), 32'(vecs[i].part));
            chk("fwd_data",    i, fwd_data,         vecs[i].fd);
            chk("last_addr",   i, last_store_addr,  vecs[i].lsa);
            chk("last_data",   i, last_store_data,  vecs[i].lsd);
        end

        // Async reset mid-stall with a full history
        @(negedge clk);
        drive(1, MEM_SW_OP, 32'h20, 32'h55, 0, 0, 32'h10);
        @(posedge clk);
        #1;
        chk("stall_mem_valid", 100, 32'(mem_valid), 32'h1);
        chk("stall_fwd_hit",   100, 32'(fwd_hit),   32'h1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mem_valid", 101, 32'(mem_valid),  32'h0);
        chk("arst_exe_ready", 101, 32'(exe_ready),  32'h1);
        chk("arst_mem_addr",  101, mem_mem_addr,    32'h0);
        chk("arst_mem_data",  101, mem_mem_data,    32'h0);
        chk("arst_mem_pc",    101, mem_pc,          32'h0);
        chk("arst_mem_op",    101, 32'(mem_mem_op), 32'(MEM_NOP_OP));
        chk("arst_fwd_hit",   101, 32'(fwd_hit),    32'h0);
        chk("arst_fwd_data",  101, fwd_data,        32'h0);
        chk("arst_last_addr", 101, last_store_addr, 32'h0);
        chk("arst_last_data", 101, last_store_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, MEM_NOP_OP, 32'h0, 32'h0, 1, 0, 32'h10);
        @(posedge clk);
        #1;
        chk("post_fwd_hit",   102, 32'(fwd_hit),     32'h0);
        chk("post_fwd_part",  102, 32'(fwd_partial), 32'h0);
        chk("post_mem_valid", 102, 32'(mem_valid),   32'h0);
        chk("post_last_addr", 102, last_store_addr,  32'h0);
        @(negedge clk);
        fwd_addr = 32'h0;
        #1;
        chk("post_fwd_hit0",  103, 32'(fwd_hit),     32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
